// File: rtl/pcre_engine_pkg.sv
// Shared constants and parameter helpers
// for the PCRE repetition engine.
package pcre_engine_pkg;

  localparam int POS_W      = 16;
  localparam int MAX_STAGES = 8;

  // Pull field idx of width w out of a packed per-stage vector
  function automatic logic [31:0] rep_field(
    input logic [255:0] v,
    input int           idx,
    input int           w
  );
    return 32'((v >> (idx * w)) & ((256'(1) << w) - 256'(1)));
  endfunction

endpackage

// File: rtl/pcre_rep_engine_stage.sv
// One char-class repetition stage:
// active bit plus bounded/unbounded repeat counter.
module rep_stage #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sod,
  input  logic             cls,
  input  logic             prev_ready,
  input  logic [CNT_W-1:0] min_rep,
  input  logic [CNT_W-1:0] max_rep,
  output logic             act,
  output logic [CNT_W-1:0] cnt,
  output logic             ready
);

  logic             r_act;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unb;
  logic             w_entry;
  logic             w_cont;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_unb   = (max_rep == '0);
  assign w_entry = cls & prev_ready;
  assign w_cont  = cls & r_act & (w_unb | (r_cnt < max_rep));
  assign w_sat   = w_unb & (r_cnt == '1);

  // Continuing wins over a fresh entry; a full bounded run restarts at 1
  always_comb begin
    w_cnt_nxt = '0;
    if (w_cont)
      w_cnt_nxt = w_sat ? r_cnt : r_cnt + 1'b1;
    else if (w_entry)
      w_cnt_nxt = CNT_W'(1);
  end

  // Stage state advances only on accepted payload bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= 1'b0;
      r_cnt <= '0;
    end else if (sod) begin
      r_act <= 1'b0;
      r_cnt <= '0;
    end else if (en) begin
      r_act <= w_entry | w_cont;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign act   = r_act;
  assign cnt   = r_cnt;
  assign ready = r_act & (r_cnt >= min_rep);

endmodule

// File: rtl/pcre_rep_engine.sv
// Chained char-class repetition matcher with
// sticky match flag and first-match position.
module pcre_rep_engine
  import pcre_engine_pkg::*;
#(
  parameter int                          N_STAGES = 4,
  parameter int                          CNT_W    = 4,
  parameter logic [N_STAGES*CNT_W-1:0]   MIN_REP  = {N_STAGES{CNT_W'(1)}},
  parameter logic [N_STAGES*CNT_W-1:0]   MAX_REP  = '0,
  parameter bit                          ANCHORED = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sod,
  input  logic                en,
  input  logic [N_STAGES-1:0] cls,
  output logic                match,
  output logic                match_pulse,
  output logic [POS_W-1:0]    match_pos,
  output logic                busy
);

  logic [POS_W-1:0]          r_bcnt;
  logic [POS_W-1:0]          r_lidx;
  logic [POS_W-1:0]          r_pos;
  logic                      r_match;
  logic                      r_pulse;
  logic [N_STAGES-1:0]       w_act;
  logic [N_STAGES-1:0]       w_ready;
  logic [N_STAGES-1:0]       w_prev;
  logic [N_STAGES*CNT_W-1:0] w_unused_cnt;
  logic                      w_first;
  logic                      w_last;
  logic                      w_hit;

  assign w_first = (r_bcnt == '0);
  assign w_last  = w_ready[N_STAGES-1];
  assign w_hit   = w_last & ~r_match;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_st
    localparam logic [CNT_W-1:0] L_MIN =
      CNT_W'(rep_field(256'(MIN_REP), i, CNT_W));
    localparam logic [CNT_W-1:0] L_MAX =
      CNT_W'(rep_field(256'(MAX_REP), i, CNT_W));

    if (i == 0) begin : g_head
      assign w_prev[i] = ANCHORED ? w_first : 1'b1;
    end else begin : g_link
      assign w_prev[i] = w_ready[i-1];
    end

    rep_stage #(
      .CNT_W(CNT_W)
    ) u_st (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sod       (sod),
      .cls       (cls[i]),
      .prev_ready(w_prev[i]),
      .min_rep   (L_MIN),
      .max_rep   (L_MAX),
      .act       (w_act[i]),
      .cnt       (w_unused_cnt[i*CNT_W +: CNT_W]),
      .ready     (w_ready[i])
    );
  end

  // Byte index tracking and end-of-chain match capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_lidx  <= '0;
      r_pos   <= '0;
      r_match <= 1'b0;
      r_pulse <= 1'b0;
    end else if (sod) begin
      r_bcnt  <= '0;
      r_lidx  <= '0;
      r_pos   <= '0;
      r_match <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      if (w_hit) begin
        r_match <= 1'b1;
        r_pos   <= r_lidx;
      end
      if (en) begin
        r_lidx <= r_bcnt;
        if (r_bcnt != '1)
          r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  assign match       = r_match;
  assign match_pulse = r_pulse;
  assign match_pos   = r_pos;
  assign busy        = |w_act;

endmodule

// File: tb/tb_pcre_rep_engine.sv
// Scoreboard bench: unanchored and anchored
// engines driven by one shared random stream.
module tb_pcre_rep_engine;

  localparam int NS = 3;
  localparam int CW = 4;
  localparam logic [NS*CW-1:0] MINP = 12'h121;
  localparam logic [NS*CW-1:0] MAXP = 12'h030;
  localparam int MINV [NS] = '{1, 2, 1};
  localparam int MAXV [NS] = '{0, 3, 0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sod = 1'b0;
  logic          en = 1'b0;
  logic [NS-1:0] cls = '0;
  logic          match0, pulse0, busy0;
  logic          match1, pulse1, busy1;
  logic [15:0]   pos0, pos1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit m;
    bit p;
    int pos;
    bit b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_act  [2][NS];
  int m_cnt  [2][NS];
  int m_bcnt [2];
  int m_lidx [2];
  int m_match[2];
  int m_pulse[2];
  int m_pos  [2];

  always #5 clk = ~clk;

  pcre_rep_engine #(
    .N_STAGES(NS), .CNT_W(CW),
    .MIN_REP(MINP), .MAX_REP(MAXP),
    .ANCHORED(1'b0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en),
    .cls(cls), .match(match0), .match_pulse(pulse0),
    .match_pos(pos0), .busy(busy0)
  );

  pcre_rep_engine #(
    .N_STAGES(NS), .CNT_W(CW),
    .MIN_REP(MINP), .MAX_REP(MAXP),
    .ANCHORED(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sod(sod), .en(en),
    .cls(cls), .match(match1), .match_pulse(pulse1),
    .match_pos(pos1), .busy(busy1)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic void model_clear(int d);
    for (int i = 0; i < NS; i++) begin
      m_act[d][i] = 0;
      m_cnt[d][i] = 0;
    end
    m_bcnt[d] = 0;
    m_lidx[d] = 0;
    m_match[d] = 0;
    m_pulse[d] = 0;
    m_pos[d] = 0;
  endfunction

  // d=1 models the anchored engine
  function automatic void model_step(int d, bit s, bit e, logic [NS-1:0] c);
    bit rdy[NS];
    int na[NS];
    int nc[NS];
    bit ent, cont;
    if (s) begin
      model_clear(d);
      return;
    end
    for (int i = 0; i < NS; i++)
      rdy[i] = m_act[d][i] != 0 && m_cnt[d][i] >= MINV[i];
    m_pulse[d] = (rdy[NS-1] && m_match[d] == 0) ? 1 : 0;
    if (m_pulse[d] != 0) begin
      m_match[d] = 1;
      m_pos[d] = m_lidx[d];
    end
    if (e) begin
      for (int i = 0; i < NS; i++) begin
        if (i == 0)
          ent = c[i] && (d == 0 || m_bcnt[d] == 0);
        else
          ent = c[i] && rdy[i-1];
        cont = c[i] && m_act[d][i] != 0 &&
               (MAXV[i] == 0 || m_cnt[d][i] < MAXV[i]);
        if (cont)
          nc[i] = (m_cnt[d][i] >= 15) ? 15 : m_cnt[d][i] + 1;
        else
          nc[i] = ent ? 1 : 0;
        na[i] = (ent || cont) ? 1 : 0;
      end
      for (int i = 0; i < NS; i++) begin
        m_act[d][i] = na[i];
        m_cnt[d][i] = nc[i];
      end
      m_lidx[d] = m_bcnt[d];
      if (m_bcnt[d] < 65535)
        m_bcnt[d]++;
    end
  endfunction

  function automatic exp_t model_exp(int d);
    exp_t x;
    x.m = m_match[d] != 0;
    x.p = m_pulse[d] != 0;
    x.pos = m_pos[d];
    x.b = 1'b0;
    for (int i = 0; i < NS; i++)
      if (m_act[d][i] != 0) x.b = 1'b1;
    return x;
  endfunction

  task automatic drive(bit s, bit e, logic [NS-1:0] c);
    @(negedge clk);
    sod = s;
    en = e;
    cls = c;
    for (int d = 0; d < 2; d++)
      model_step(d, s, e, c);
    q0.push_back(model_exp(0));
    q1.push_back(model_exp(1));
  endtask

  // Monitor: one expected entry per clock edge after stimulus
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("d0_match", 32'(match0), 32'(x.m));
      chk("d0_pulse", 32'(pulse0), 32'(x.p));
      chk("d0_pos", 32'(pos0), 32'(x.pos));
      chk("d0_busy", 32'(busy0), 32'(x.b));
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("d1_match", 32'(match1), 32'(x.m));
      chk("d1_pulse", 32'(pulse1), 32'(x.p));
      chk("d1_pos", 32'(pos1), 32'(x.pos));
      chk("d1_busy", 32'(busy1), 32'(x.b));
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_m0"}, 32'(match0), 0);
    chk({nm, "_p0"}, 32'(pulse0), 0);
    chk({nm, "_pos0"}, 32'(pos0), 0);
    chk({nm, "_b0"}, 32'(busy0), 0);
    chk({nm, "_m1"}, 32'(match1), 0);
    chk({nm, "_p1"}, 32'(pulse1), 0);
    chk({nm, "_pos1"}, 32'(pos1), 0);
    chk({nm, "_b1"}, 32'(busy1), 0);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic rand_run(int n);
    repeat (n)
      drive(($urandom % 32) == 0, ($urandom % 4) != 0, NS'($urandom));
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simple chain from byte 0: both engines match at index 3
    drive(0, 1, 3'b001);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(3);

    // Pattern starting at index 1: anchored engine must stay quiet
    drive(1, 0, '0);
    drive(0, 1, 3'b000);
    drive(0, 1, 3'b001);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(3);

    // Bounded stage overrun, then exact max run
    drive(1, 0, '0);
    drive(0, 1, 3'b001);
    repeat (4) drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    drive(0, 1, 3'b001);
    repeat (3) drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(2);

    // Gaps in en mid-pattern
    drive(1, 0, '0);
    drive(0, 1, 3'b001);
    drive(0, 0, 3'b111);
    drive(0, 1, 3'b010);
    drive(0, 0, 3'b000);
    drive(0, 1, 3'b010);
    drive(0, 0, 3'b100);
    drive(0, 1, 3'b100);
    idle(3);

    // sod mid-pattern
    drive(1, 0, '0);
    drive(0, 1, 3'b001);
    drive(0, 1, 3'b010);
    drive(1, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(2);

    // Long unbounded head run saturates its counter
    drive(1, 0, '0);
    repeat (20) drive(0, 1, 3'b001);
    drive(0, 1, 3'b011);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(3);

    rand_run(1500);
    idle(2);

    // Async reset mid-cycle, away from the clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 1, 3'b001);
    drive(0, 1, 3'b011);
    drive(0, 1, 3'b010);
    drive(0, 1, 3'b100);
    idle(3);

    rand_run(1500);
    idle(3);
    @(posedge clk);
    #3;
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
